// File: rtl/interleaver_pingpong_ctrl_pkg.sv
// rtl/interleaver_pingpong_ctrl_pkg.sv - shared read-FSM states and write-permutation helper
package wimax_pkg;

  // Read FSM encoding
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_READ = 2'd1;
  localparam logic [1:0] R_LAST = 2'd2;

  // Second permutation step: rotates the bit within each group of s bits by the column number
  function automatic int perm_index(input int m, input int col, input int s, input int ncbps);
    return s * (m / s) + (m + ncbps - col) % s;
  endfunction

endpackage

// File: rtl/interleaver_pingpong_ctrl_if.sv
// rtl/interleaver_pingpong_ctrl_if.sv - FEC/RAM/modulator handshake bundle
interface interleaver_pingpong_ctrl_if #(
  parameter int AW = 8
);
  logic          valid_fec;
  logic          ready_interleaver;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          valid_interleaver;
  logic          ready_mod;
  logic [AW-1:0] data_out_index;
  logic          block_done;

  // Controller side
  modport master (
    input  valid_fec, ready_mod,
    output ready_interleaver, wr_en, wr_bank, wr_addr,
    output rd_en, rd_bank, rd_addr, valid_interleaver, data_out_index, block_done
  );

  // FEC / RAM / modulator side
  modport slave (
    output valid_fec, ready_mod,
    input  ready_interleaver, wr_en, wr_bank, wr_addr,
    input  rd_en, rd_bank, rd_addr, valid_interleaver, data_out_index, block_done
  );
endinterface

// File: rtl/interleaver_pingpong_ctrl_perm_gen.sv
// rtl/interleaver_pingpong_ctrl_perm_gen.sv - k/col/row/m counters and permuted write index
module interleaver_perm_gen
  import wimax_pkg::*;
#(
  parameter int Ncbps = 192,
  parameter int s     = 1,
  parameter int d     = 16,
  localparam int AW   = $clog2(Ncbps),
  localparam int R    = Ncbps / d,
  localparam int CW   = (d > 1) ? $clog2(d) : 1,
  localparam int RW   = (R > 1) ? $clog2(R) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  output logic [AW-1:0] wr_addr,
  output logic          last
);

  logic [AW-1:0] k_q, k_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] m_q, m_d;

  assign last    = (k_q == AW'(Ncbps - 1));
  assign wr_addr = AW'(perm_index(int'(m_q), int'(col_q), s, Ncbps));

  // Step the first permutation incrementally: m walks down a column, restarting at the next row
  always_comb begin
    k_d   = k_q;
    col_d = col_q;
    row_d = row_q;
    m_d   = m_q;
    if (advance) begin
      if (last) begin
        k_d   = '0;
        col_d = '0;
        row_d = '0;
        m_d   = '0;
      end else begin
        k_d = k_q + AW'(1);
        if (col_q == CW'(d - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
          m_d   = AW'(row_q) + AW'(1);
        end else begin
          col_d = col_q + CW'(1);
          m_d   = m_q + AW'(R);
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q   <= '0;
      col_q <= '0;
      row_q <= '0;
      m_q   <= '0;
    end else begin
      k_q   <= k_d;
      col_q <= col_d;
      row_q <= row_d;
      m_q   <= m_d;
    end
  end

endmodule

// File: rtl/interleaver_pingpong_ctrl.sv
// rtl/interleaver_pingpong_ctrl.sv - ping-pong bank sequencer for the block interleaver RAM
module interleaver_pingpong_ctrl
  import wimax_pkg::*;
#(
  parameter int Ncbps = 192,
  parameter int Ncpc  = 2,
  parameter int s     = Ncpc / 2,
  parameter int d     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  interleaver_pingpong_ctrl_if.master   bus
);

  localparam int AW = $clog2(Ncbps);

  logic [1:0]    bank_full_q, bank_full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;

  logic          ready_w, wr_en_w, wr_last, wr_done;
  logic          rd_en_w, accept_w, block_done_w;
  logic [AW-1:0] wr_addr_w;
  logic [1:0]    set_w, clr_w;

  // Reset gates the combinational strobes so nothing is accepted or pulsed while held
  assign ready_w  = !reset && !bank_full_q[wr_bank_q];
  assign wr_en_w  = bus.valid_fec && ready_w;
  assign wr_done  = wr_en_w && wr_last;
  assign accept_w = valid_q && bus.ready_mod;

  interleaver_perm_gen #(
    .Ncbps (Ncbps),
    .s     (s),
    .d     (d)
  ) u_perm_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (wr_en_w),
    .wr_addr (wr_addr_w),
    .last    (wr_last)
  );

  // Bank flags and read FSM; IDLE/LAST look at next-cycle flags so a fresh bank starts at once
  always_comb begin
    rd_en_w      = 1'b0;
    block_done_w = 1'b0;
    clr_w        = 2'b00;
    set_w        = 2'b00;
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    rd_bank_d    = rd_bank_q;
    wr_bank_d    = wr_bank_q ^ wr_done;
    valid_d      = valid_q;
    idx_d        = idx_q;

    if (wr_done) set_w[wr_bank_q] = 1'b1;

    if (state_q == R_READ) begin
      rd_en_w = !valid_q || bus.ready_mod;
      if (rd_en_w) begin
        if (rd_addr_q == AW'(Ncbps - 1)) begin
          clr_w[rd_bank_q] = 1'b1;
          rd_bank_d        = !rd_bank_q;
          rd_addr_d        = '0;
          state_d          = R_LAST;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
    end

    bank_full_d = (bank_full_q & ~clr_w) | set_w;

    if (state_q == R_IDLE && bank_full_d[rd_bank_q]) state_d = R_READ;
    if (state_q == R_LAST && accept_w) begin
      block_done_w = 1'b1;
      state_d      = bank_full_d[rd_bank_q] ? R_READ : R_IDLE;
    end

    if (rd_en_w) begin
      valid_d = 1'b1;
      idx_d   = rd_addr_q;
    end else if (accept_w) begin
      valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      state_q     <= R_IDLE;
      rd_addr_q   <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.ready_interleaver = ready_w;
  assign bus.wr_en             = wr_en_w;
  assign bus.wr_bank           = wr_bank_q;
  assign bus.wr_addr           = wr_addr_w;
  assign bus.rd_en             = rd_en_w && !reset;
  assign bus.rd_bank           = rd_bank_q;
  assign bus.rd_addr           = rd_addr_q;
  assign bus.valid_interleaver = valid_q;
  assign bus.data_out_index    = idx_q;
  assign bus.block_done        = block_done_w && !reset;

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// tb/tb_interleaver_pingpong_ctrl.sv - self-checking bench for interleaver_pingpong_ctrl
module tb_interleaver_pingpong_ctrl;

  localparam int NC = 192;
  localparam int D  = 16;
  localparam int RR = NC / D;
  localparam int AW = 8;
  localparam logic [191:0] GOLD_IN_C  = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
  localparam logic [191:0] GOLD_OUT_C = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;

  typedef struct {
    int dut;
    int k;
    int addr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interleaver_pingpong_ctrl_if #(.AW(AW)) a_if ();
  interleaver_pingpong_ctrl_if #(.AW(AW)) b_if ();

  interleaver_pingpong_ctrl #(.Ncbps(NC), .Ncpc(2), .s(1), .d(D)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  interleaver_pingpong_ctrl #(.Ncbps(NC), .Ncpc(4), .s(2), .d(D)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  int n_chk = 0;
  int n_fail = 0;
  int vmode = 0;
  int rmode = 1;
  int bmode = 0;
  bit gold_chk = 0;
  logic fec_bit;
  logic [191:0] gold_in, gold_out, out_vec;
  bit model_in[$];
  bit exp_q[$];
  int out_j = 0, wr_total = 0, done_dut = 0, in_blocks = 0, b_cnt = 0;
  int hist_a[NC];
  int hist_b[NC];
  logic mem_bits[2][NC];
  logic ram_q;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: output bit j of a block is the input bit k whose column/row position maps to j
  task automatic push_block();
    bit blk[NC];
    for (int k = 0; k < NC; k++) blk[RR * (k % D) + k / D] = model_in[k];
    for (int j = 0; j < NC; j++) exp_q.push_back(blk[j]);
    model_in.delete();
  endtask

  task automatic check_output();
    bit e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL out_unexpected: got index %0d expected no output", a_if.data_out_index);
    end else begin
      e = exp_q.pop_front();
      chk("out_bit", int'(ram_q), int'(e));
      chk("out_index", int'(a_if.data_out_index), out_j);
      chk("block_done", int'(a_if.block_done), (out_j == NC - 1) ? 1 : 0);
      out_vec[a_if.data_out_index] = ram_q;
      if (out_j == NC - 1 && gold_chk) begin
        n_chk++;
        if (out_vec !== gold_out) begin
          n_fail++;
          $display("FAIL golden_block: got %h expected %h", out_vec, gold_out);
        end
      end
      out_j = (out_j + 1) % NC;
    end
  endtask

  // Datapath RAM with a registered read port that holds when rd_en is low
  always @(posedge clk) begin
    if (a_if.wr_en) mem_bits[a_if.wr_bank][a_if.wr_addr] <= fec_bit;
    if (a_if.rd_en) ram_q <= mem_bits[a_if.rd_bank][a_if.rd_addr];
  end

  // Monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      model_in.delete();
      exp_q.delete();
      out_j = 0; wr_total = 0; in_blocks = 0; b_cnt = 0; done_dut = 0;
    end else begin
      if (b_if.wr_en) begin
        if (b_cnt < NC) hist_b[b_cnt] = int'(b_if.wr_addr);
        b_cnt++;
      end
      if (a_if.block_done) done_dut++;
      if (a_if.valid_interleaver && a_if.ready_mod) check_output();
      if (a_if.wr_en) begin
        if (in_blocks == 0) hist_a[model_in.size()] = int'(a_if.wr_addr);
        model_in.push_back(fec_bit);
        wr_total++;
        if (model_in.size() == NC) begin
          push_block();
          in_blocks++;
        end
      end
    end
  end

  // Input driver, just after each rising edge
  initial begin
    a_if.valid_fec = 1'b0; a_if.ready_mod = 1'b0; fec_bit = 1'b0;
    b_if.valid_fec = 1'b1; b_if.ready_mod = 1'b1;
    forever begin
      @(posedge clk); #1;
      a_if.valid_fec = (vmode == 1) || (vmode == 2 && $urandom_range(0, 9) < 7);
      a_if.ready_mod = (rmode == 1) || (rmode == 2 && $urandom_range(0, 9) < 6);
      fec_bit = (bmode == 0) ? gold_in[model_in.size()] : 1'($urandom);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
  endtask

  initial begin
    bit found;
    gold_in  = GOLD_IN_C;
    gold_out = GOLD_OUT_C;
    for (int i = 0; i < NC; i++) begin hist_a[i] = -1; hist_b[i] = -1; end
    tbl[0]  = '{0, 0, 0};     tbl[1]  = '{0, 1, 12};   tbl[2]  = '{0, 2, 24};
    tbl[3]  = '{0, 15, 180};  tbl[4]  = '{0, 16, 1};   tbl[5]  = '{0, 17, 13};
    tbl[6]  = '{0, 191, 191}; tbl[7]  = '{1, 0, 0};    tbl[8]  = '{1, 1, 13};
    tbl[9]  = '{1, 16, 1};    tbl[10] = '{1, 17, 12};

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(a_if.ready_interleaver), 0);
    chk("rst_wr_en", int'(a_if.wr_en), 0);
    chk("rst_rd_en", int'(a_if.rd_en), 0);
    chk("rst_valid", int'(a_if.valid_interleaver), 0);
    chk("rst_wr_addr", int'(a_if.wr_addr), 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", int'(a_if.ready_interleaver), 1);
    chk("idle_wr_bank", int'(a_if.wr_bank), 0);
    chk("idle_rd_en", int'(a_if.rd_en), 0);

    // Golden block, 10 times back to back, with first-block latency
    gold_chk = 1; bmode = 0; rmode = 1; vmode = 1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (a_if.wr_en && a_if.wr_addr == 8'd191) found = 1;
    end
    chk("lat_last_wr_seen", int'(found), 1);
    @(negedge clk);
    chk("lat_rd_en", int'(a_if.rd_en), 1);
    chk("lat_rd_addr", int'(a_if.rd_addr), 0);
    chk("lat_wr_bank", int'(a_if.wr_bank), 1);
    chk("lat_ready", int'(a_if.ready_interleaver), 1);
    @(negedge clk);
    chk("lat_valid", int'(a_if.valid_interleaver), 1);
    chk("lat_index", int'(a_if.data_out_index), 0);
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk); #1;
      if (done_dut >= 10) found = 1;
    end
    chk("golden_10_blocks_done", int'(found), 1);
    for (int i = 0; i < 11; i++)
      chk($sformatf("wr_addr_dut%0d_k%0d", tbl[i].dut, tbl[i].k),
          (tbl[i].dut == 0) ? hist_a[tbl[i].k] : hist_b[tbl[i].k], tbl[i].addr);
    gold_chk = 0; vmode = 0;

    // Modulator stalled: both banks fill, then draining frees bank 0
    bmode = 1; rmode = 0;
    do_reset();
    vmode = 1;
    repeat (500) @(negedge clk);
    #1;
    chk("stall_ready", int'(a_if.ready_interleaver), 0);
    chk("stall_wr_total", wr_total, 2 * NC);
    rmode = 1;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (a_if.rd_en && a_if.rd_addr == 8'd191) found = 1;
    end
    chk("drain_last_rd_seen", int'(found), 1);
    chk("drain_rd_bank", int'(a_if.rd_bank), 0);
    chk("drain_ready_before", int'(a_if.ready_interleaver), 0);
    @(negedge clk);
    chk("drain_ready_after", int'(a_if.ready_interleaver), 1);
    chk("drain_wr_bank", int'(a_if.wr_bank), 0);
    vmode = 0;

    // Random handshakes against the reference model
    do_reset();
    vmode = 2; rmode = 2;
    repeat (4000) @(negedge clk);
    vmode = 0; rmode = 1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) found = 1;
    end
    chk("rand_drained", int'(found), 1);
    chk("rand_block_done_count", done_dut, wr_total / NC);

    // Reset mid-block at k=100 of the second block
    do_reset();
    vmode = 1; rmode = 1;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk); #1;
      if (wr_total == NC + 100) found = 1;
    end
    chk("midrst_k100_seen", int'(found), 1);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("midrst_wr_en", int'(a_if.wr_en), 0);
    chk("midrst_block_done", int'(a_if.block_done), 0);
    @(negedge clk);
    chk("midrst_ready", int'(a_if.ready_interleaver), 0);
    chk("midrst_rd_en", int'(a_if.rd_en), 0);
    chk("midrst_valid", int'(a_if.valid_interleaver), 0);
    chk("midrst_wr_bank", int'(a_if.wr_bank), 0);
    chk("midrst_rd_bank", int'(a_if.rd_bank), 0);
    chk("midrst_wr_addr", int'(a_if.wr_addr), 0);
    chk("midrst_rd_addr", int'(a_if.rd_addr), 0);
    chk("midrst_index", int'(a_if.data_out_index), 0);
    @(posedge clk); #1; reset = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (a_if.wr_en) found = 1;
    end
    chk("post_rst_write_seen", int'(found), 1);
    chk("post_rst_wr_bank", int'(a_if.wr_bank), 0);
    chk("post_rst_wr_addr", int'(a_if.wr_addr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
